// File: rtl/xfer_pkg.sv
// xfer_pkg: shared definitions for the register-transfer sequencer.
//   NUM_REGS / IDX_W : register file size and index width
//   CNT_W            : width of the phase counter
//   xfer_state_e     : sequencer states
//   xfer_req_t       : captured (src, dst) request pair
//   idx_onehot()     : register index to one-hot enable vector
package xfer_pkg;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        STROBE  = 2'd2,
        RELEASE = 2'd3
    } xfer_state_e;

    typedef struct packed {
        logic [IDX_W-1:0] src;
        logic [IDX_W-1:0] dst;
    } xfer_req_t;

    function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/xfer_sequencer_if.sv
// xfer_sequencer_if: request/status/bus-control bundle of the sequencer.
//   start, src, dst       : transfer request (driven by master)
//   busy, done, err, qfull: status (driven by slave)
//   oe, latch             : one-hot source enables / destination latch strobes
// Modports: master (requester side), slave (sequencer side).
interface xfer_sequencer_if;

    logic                           start;
    logic [xfer_pkg::IDX_W-1:0]     src;
    logic [xfer_pkg::IDX_W-1:0]     dst;
    logic                           busy;
    logic                           done;
    logic                           err;
    logic                           qfull;
    logic [xfer_pkg::NUM_REGS-1:0]  oe;
    logic [xfer_pkg::NUM_REGS-1:0]  latch;

    modport master (
        output start, src, dst,
        input  busy, done, err, qfull, oe, latch
    );

    modport slave (
        input  start, src, dst,
        output busy, done, err, qfull, oe, latch
    );

endinterface

// File: rtl/xfer_sequencer_phase_timer.sv
// phase_timer: down-counter timing each sequencer phase.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : reload counter with load_val (phase entry)
//   load_val   : phase length minus one
//   count      : decrement enable; holds at zero, never wraps
//   expire     : counter is zero, i.e. current cycle is the last of the phase
module phase_timer
    import xfer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             count,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/xfer_sequencer.sv
// xfer_sequencer: sequences one register-to-register transfer:
//   DRIVE   : oe[src] on for SETTLE cycles so the bus settles
//   STROBE  : latch[dst] held high for LATCH_HOLD cycles
//   RELEASE : one cycle with oe[src] only, then done pulses in the next cycle
// Parameters: SETTLE (1..15), LATCH_HOLD (1..15).
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; aborts any transfer without done
//   bus   : xfer_sequencer_if.slave (start/src/dst in; busy/done/err/qfull/oe/latch out)
// Build option: define XFER_QUEUE_EN for a one-entry pending-request buffer;
// otherwise starts while busy are ignored and qfull is tied low.
module xfer_sequencer
    import xfer_pkg::*;
#(
    parameter int unsigned SETTLE     = 1,
    parameter int unsigned LATCH_HOLD = 2
)
(
    input  logic               clk,
    input  logic               reset,
    xfer_sequencer_if.slave    bus
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(LATCH_HOLD - 1);

    xfer_state_e      state;
    xfer_state_e      state_nxt;
    xfer_req_t        cur_q;
    xfer_req_t        live_req;
    xfer_req_t        cand_req;
    logic             cand_valid;
    logic             accept;
    logic             reject;
    logic             done_q;
    logic             err_q;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expire;

    assign live_req.src = bus.src;
    assign live_req.dst = bus.dst;

`ifdef XFER_QUEUE_EN
    xfer_req_t        pend_q;
    logic             pend_valid;
    logic             dequeue;
`endif

    // Candidate request for launch: only in IDLE, or in RELEASE (its last and
    // only cycle) when a request is pending. A pending request always wins
    // over a live start, which is ignored while the buffer is full.
    always_comb begin
        cand_valid = 1'b0;
        cand_req   = live_req;
        if (state == IDLE) begin
`ifdef XFER_QUEUE_EN
            if (pend_valid) begin
                cand_valid = 1'b1;
                cand_req   = pend_q;
            end else
`endif
            if (bus.start) begin
                cand_valid = 1'b1;
            end
        end
`ifdef XFER_QUEUE_EN
        else if ((state == RELEASE) && pend_valid) begin
            cand_valid = 1'b1;
            cand_req   = pend_q;
        end
`endif
    end

    assign accept = cand_valid && (cand_req.src != cand_req.dst);
    assign reject = cand_valid && (cand_req.src == cand_req.dst);

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = DRIVE;
                    tmr_load  = 1'b1;
                    tmr_val   = SETTLE_LD;
                end
            end
            DRIVE: begin
                if (tmr_expire) begin
                    state_nxt = STROBE;
                    tmr_load  = 1'b1;
                    tmr_val   = HOLD_LD;
                end
            end
            STROBE: begin
                if (tmr_expire) begin
                    state_nxt = RELEASE;
                    tmr_load  = 1'b1;
                    tmr_val   = '0;
                end
            end
            RELEASE: begin
                if (accept) begin
                    state_nxt = DRIVE;
                    tmr_load  = 1'b1;
                    tmr_val   = SETTLE_LD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    phase_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (~tmr_load),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cur_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == RELEASE);
            err_q  <= reject;
            if (accept) begin
                cur_q <= cand_req;
            end
        end
    end

`ifdef XFER_QUEUE_EN
    assign dequeue = cand_valid && pend_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_q     <= '0;
        end else if (dequeue) begin
            pend_valid <= 1'b0;
        end else if ((state != IDLE) && bus.start && !pend_valid) begin
            pend_valid <= 1'b1;
            pend_q     <= live_req;
        end
    end

    assign bus.qfull = pend_valid;
`else
    assign bus.qfull = 1'b0;
`endif

    assign bus.busy  = (state != IDLE);
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.oe    = (state != IDLE)   ? idx_onehot(cur_q.src) : '0;
    assign bus.latch = (state == STROBE) ? idx_onehot(cur_q.dst) : '0;

endmodule

// File: tb/tb_xfer_sequencer.sv
// tb_xfer_sequencer: scoreboard bench for xfer_sequencer.
// Two instances: dut (defaults) and dut2 (SETTLE=3, LATCH_HOLD=1).
// Expected per-cycle outputs are queued when stimulus is driven and
// compared on the falling edge of the cycle they belong to.
module tb_xfer_sequencer;
    import xfer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    xfer_sequencer_if bus0 ();
    xfer_sequencer_if bus1 ();

    xfer_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    xfer_sequencer #(.SETTLE(3), .LATCH_HOLD(1)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct {
        int unsigned cyc;
        logic [7:0]  oe;
        logic [7:0]  latch;
        logic        busy;
        logic        done;
        logic        err;
        logic        qfull;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb1[$];
    int unsigned cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int id, input int unsigned c, input logic [7:0] oe,
                        input logic [7:0] la, input logic busy, input logic done,
                        input logic err, input logic qfull);
        exp_t e;
        e.cyc = c; e.oe = oe; e.latch = la;
        e.busy = busy; e.done = done; e.err = err; e.qfull = qfull;
        if (id == 0) sb0.push_back(e);
        else         sb1.push_back(e);
    endtask

    task automatic push_idle(input int id, input int unsigned c, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) push(id, c + i, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One transfer accepted at edge a: busy/oe for settle+hold+1 cycles,
    // latch for the hold window, optional done on the first busy cycle
    // (chained launch) and optional idle done cycle after it.
    task automatic push_xfer(input int id, input int unsigned a, input int unsigned src,
                             input int unsigned dst, input int unsigned settle,
                             input int unsigned hold, input bit done_first, input bit done_tail);
        int unsigned t;
        logic [7:0]  oe_e;
        logic [7:0]  la_e;
        t    = settle + hold + 1;
        oe_e = 8'h01 << src;
        for (int unsigned i = 0; i < t; i++) begin
            la_e = (i >= settle && i < settle + hold) ? (8'h01 << dst) : 8'h00;
            push(id, a + i, oe_e, la_e, 1'b1, done_first && (i == 0), 1'b0, 1'b0);
        end
        if (done_tail) push(id, a + t, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic cmp(input int id, input exp_t e, input logic [7:0] oe, input logic [7:0] la,
                       input logic busy, input logic done, input logic err, input logic qfull);
        string p;
        p = $sformatf("d%0d.c%0d", id, e.cyc);
        check({p, ".oe"},    32'(oe),    32'(e.oe));
        check({p, ".latch"}, 32'(la),    32'(e.latch));
        check({p, ".busy"},  32'(busy),  32'(e.busy));
        check({p, ".done"},  32'(done),  32'(e.done));
        check({p, ".err"},   32'(err),   32'(e.err));
        check({p, ".qfull"}, 32'(qfull), 32'(e.qfull));
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb0.size() > 0 && sb0[0].cyc <= cyc) begin
            e = sb0.pop_front();
            if (e.cyc != cyc) check("d0.order", cyc, e.cyc);
            else cmp(0, e, bus0.oe, bus0.latch, bus0.busy, bus0.done, bus0.err, bus0.qfull);
        end
        if (sb1.size() > 0 && sb1[0].cyc <= cyc) begin
            e = sb1.pop_front();
            if (e.cyc != cyc) check("d1.order", cyc, e.cyc);
            else cmp(1, e, bus1.oe, bus1.latch, bus1.busy, bus1.done, bus1.err, bus1.qfull);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int unsigned a;
        reset      = 1'b1;
        bus0.start = 1'b0; bus0.src = '0; bus0.dst = '0;
        bus1.start = 1'b0; bus1.src = '0; bus1.dst = '0;

        // Reset state
        tick();
        push_idle(0, cyc, 3);
        push_idle(1, cyc, 3);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Basic transfer src=2 -> dst=5, default timing
        bus0.start = 1'b1; bus0.src = 3'd2; bus0.dst = 3'd5;
        a = cyc + 1;
        push_xfer(0, a, 2, 5, 1, 2, 1'b0, 1'b1);
        push_idle(0, a + 5, 1);
        tick();
        bus0.start = 1'b0;
        repeat (6) tick();

        // Rejected request src==dst
        bus0.start = 1'b1; bus0.src = 3'd3; bus0.dst = 3'd3;
        push(0, cyc + 1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        push_idle(0, cyc + 2, 2);
        tick();
        bus0.start = 1'b0;
        repeat (3) tick();

        // Reset during STROBE; reset also wins over a simultaneous start
        bus0.start = 1'b1; bus0.src = 3'd1; bus0.dst = 3'd4;
        a = cyc + 1;
        push(0, a,     8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        push(0, a + 1, 8'h02, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        push_idle(0, a + 2, 5);
        tick();
        bus0.start = 1'b0;
        tick();
        reset = 1'b1;
        bus0.start = 1'b1; bus0.src = 3'd0; bus0.dst = 3'd6;
        tick();
        reset = 1'b0;
        bus0.start = 1'b0;
        repeat (5) tick();

        // Non-default timing on dut2: SETTLE=3, LATCH_HOLD=1, src=0 -> dst=7
        bus1.start = 1'b1; bus1.src = 3'd0; bus1.dst = 3'd7;
        a = cyc + 1;
        push_xfer(1, a, 0, 7, 3, 1, 1'b0, 1'b1);
        push_idle(1, a + 6, 1);
        tick();
        bus1.start = 1'b0;
        repeat (7) tick();

`ifndef XFER_QUEUE_EN
        // start held high: back-to-back transfers every 5 cycles
        bus0.start = 1'b1; bus0.src = 3'd2; bus0.dst = 3'd5;
        a = cyc + 1;
        for (int unsigned n = 0; n < 3; n++) push_xfer(0, a + 5 * n, 2, 5, 1, 2, 1'b0, 1'b1);
        push_idle(0, a + 15, 2);
        tick();
        repeat (10) tick();
        bus0.start = 1'b0;
        repeat (7) tick();
`else
        // Queued second request launches from RELEASE; third start ignored
        bus0.start = 1'b1; bus0.src = 3'd2; bus0.dst = 3'd5;
        a = cyc + 1;
        push_xfer(0, a, 2, 5, 1, 2, 1'b0, 1'b0);
        for (int i = 0; i < sb0.size(); i++)
            if (sb0[i].cyc >= a + 1 && sb0[i].cyc <= a + 3) sb0[i].qfull = 1'b1;
        push_xfer(0, a + 4, 6, 1, 1, 2, 1'b1, 1'b1);
        push_idle(0, a + 9, 3);
        tick();
        bus0.src = 3'd6; bus0.dst = 3'd1;
        tick();
        bus0.src = 3'd0; bus0.dst = 3'd3;
        tick();
        bus0.start = 1'b0;
        repeat (12) tick();
`endif

        for (int i = 0; i < 50 && (sb0.size() > 0 || sb1.size() > 0); i++) tick();
        if (sb0.size() > 0 || sb1.size() > 0) check("sb.drain", sb0.size() + sb1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
